// File: rtl/branch_target_table.sv
// branch_target_table
// Branch target lookup table for the fetch stage. Maps a short branch index
// to a full target address, with a valid bit per entry so lookups report
// hit/miss. A sequential clear engine sweeps the table after reset and on a
// flush, so the storage has no reset and maps onto RAM-style arrays.
//
// Ports:
//   clk        clock, all state updates on the rising edge
//   reset      asynchronous, active-high
//   rd_en      lookup request
//   rd_index   entry to look up
//   rd_target  registered lookup result, 0 on miss
//   rd_hit     registered, 1 when the looked-up entry was valid
//   wr_valid   write request
//   wr_ready   write can be accepted (combinational from state)
//   wr_index   entry to write
//   wr_target  target to store, entry becomes valid
//   flush_req  single-cycle pulse, invalidates the whole table
//   busy       clear engine running
//
// Build option:
//   BLUT_FWD_EN  when defined, a same-cycle accepted write and lookup to the
//                same in-range index returns the data being written.
module branch_target_table #(
    parameter int ADDR_W = 10,
    parameter int DEPTH  = 32,
    parameter int IDX_W  = $clog2(DEPTH)
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              rd_en,
    input  logic [IDX_W-1:0]  rd_index,
    output logic [ADDR_W-1:0] rd_target,
    output logic              rd_hit,
    input  logic              wr_valid,
    output logic              wr_ready,
    input  logic [IDX_W-1:0]  wr_index,
    input  logic [ADDR_W-1:0] wr_target,
    input  logic              flush_req,
    output logic              busy
);

    // Widened by one bit so the range test also works for DEPTH == 2**IDX_W.
    localparam logic [IDX_W:0]   DEPTH_C  = (IDX_W+1)'(DEPTH);
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(DEPTH - 1);

    typedef enum logic [0:0] {
        ST_CLEAR = 1'b0,
        ST_IDLE  = 1'b1
    } state_t;

    state_t             state_r;
    state_t             state_next_s;
    logic [IDX_W-1:0]   clr_cnt_r;

    logic               valid_r  [DEPTH];
    logic [ADDR_W-1:0]  target_r [DEPTH];

    logic               wr_accept_s;
    logic               wr_in_range_s;
    logic               rd_in_range_s;
    logic               mem_we_s;
    logic [IDX_W-1:0]   mem_idx_s;
    logic               mem_vld_s;
    logic [ADDR_W-1:0]  mem_tgt_s;
    logic               lk_hit_s;
    logic [ADDR_W-1:0]  lk_tgt_s;

    assign wr_accept_s   = wr_valid && wr_ready;
    assign wr_in_range_s = ({1'b0, wr_index} < DEPTH_C);
    assign rd_in_range_s = ({1'b0, rd_index} < DEPTH_C);

    // State register.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_r <= ST_CLEAR;
        end else begin
            state_r <= state_next_s;
        end
    end

    // Next-state logic: sweep until the last entry, flush only honoured in IDLE.
    always_comb begin
        state_next_s = state_r;
        case (state_r)
            ST_CLEAR: begin
                if (clr_cnt_r == LAST_IDX) begin
                    state_next_s = ST_IDLE;
                end else begin
                    state_next_s = ST_CLEAR;
                end
            end
            ST_IDLE: begin
                if (flush_req) begin
                    state_next_s = ST_CLEAR;
                end else begin
                    state_next_s = ST_IDLE;
                end
            end
            default: state_next_s = ST_CLEAR;
        endcase
    end

    // Output decode from state.
    always_comb begin
        busy     = 1'b1;
        wr_ready = 1'b0;
        case (state_r)
            ST_CLEAR: begin
                busy     = 1'b1;
                wr_ready = 1'b0;
            end
            ST_IDLE: begin
                busy     = 1'b0;
                wr_ready = 1'b1;
            end
            default: begin
                busy     = 1'b1;
                wr_ready = 1'b0;
            end
        endcase
    end

    // Clear counter: advances every CLEAR edge, wraps to 0 after the last entry.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            clr_cnt_r <= '0;
        end else if (state_r == ST_CLEAR) begin
            if (clr_cnt_r == LAST_IDX) begin
                clr_cnt_r <= '0;
            end else begin
                clr_cnt_r <= clr_cnt_r + IDX_W'(1);
            end
        end else begin
            clr_cnt_r <= '0;
        end
    end

    // Single storage write port shared by the clear engine and the write port.
    // wr_ready is low in CLEAR, so the two never compete.
    always_comb begin
        mem_we_s  = 1'b0;
        mem_idx_s = '0;
        mem_vld_s = 1'b0;
        mem_tgt_s = '0;
        if (state_r == ST_CLEAR) begin
            mem_we_s  = 1'b1;
            mem_idx_s = clr_cnt_r;
            mem_vld_s = 1'b0;
            mem_tgt_s = '0;
        end else if (wr_accept_s && wr_in_range_s) begin
            mem_we_s  = 1'b1;
            mem_idx_s = wr_index;
            mem_vld_s = 1'b1;
            mem_tgt_s = wr_target;
        end else begin
            mem_we_s  = 1'b0;
        end
    end

    // Table storage, intentionally without reset.
    always_ff @(posedge clk) begin
        if (mem_we_s) begin
            valid_r[mem_idx_s]  <= mem_vld_s;
            target_r[mem_idx_s] <= mem_tgt_s;
        end
    end

    // Lookup: out-of-range misses; optional forwarding of a same-cycle write.
    always_comb begin
        lk_hit_s = 1'b0;
        lk_tgt_s = '0;
        if (!rd_in_range_s) begin
            lk_hit_s = 1'b0;
            lk_tgt_s = '0;
`ifdef BLUT_FWD_EN
        end else if (wr_accept_s && wr_in_range_s && (wr_index == rd_index)) begin
            lk_hit_s = 1'b1;
            lk_tgt_s = wr_target;
`endif
        end else if (valid_r[rd_index]) begin
            lk_hit_s = 1'b1;
            lk_tgt_s = target_r[rd_index];
        end else begin
            lk_hit_s = 1'b0;
            lk_tgt_s = '0;
        end
    end

    // Registered lookup result, held while rd_en is low.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            rd_hit    <= 1'b0;
            rd_target <= '0;
        end else if (rd_en) begin
            rd_hit    <= lk_hit_s;
            rd_target <= lk_tgt_s;
        end
    end

endmodule
